// File: rtl/read_path_aligner.sv
// Read stage of the multi-port RAM: per read agent, aligns the last-writer select with the bank
// read latency, muxes that bank and registers rddata with rdvalid/rderr. Optional feature macro: WR_BYPASS_EN.
module read_path_aligner #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int NB_WRAGENT   = 2,
  parameter int NB_RDAGENT   = 2,
  parameter int SELECT_WIDTH = (NB_WRAGENT > 1) ? $clog2(NB_WRAGENT) : 1,
  parameter int RAM_LATENCY  = 1
) (
  input  logic                                        aclk,
  input  logic                                        srst,
  input  logic [NB_RDAGENT-1:0]                       rden,
  input  logic [NB_RDAGENT*ADDR_WIDTH-1:0]            rdaddr,
  input  logic [NB_RDAGENT*SELECT_WIDTH-1:0]          rdselect,
  input  logic [NB_RDAGENT*NB_WRAGENT*DATA_WIDTH-1:0] bank_rddata,
  input  logic [NB_WRAGENT-1:0]                       wren,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0]            wraddr,
  input  logic [NB_WRAGENT*DATA_WIDTH-1:0]            wrdata,
  output logic [NB_RDAGENT-1:0]                       rdvalid,
  output logic [NB_RDAGENT*DATA_WIDTH-1:0]            rddata,
  output logic [NB_RDAGENT-1:0]                       rderr
);

  localparam int                    LAST     = RAM_LATENCY - 1;
  localparam logic [SELECT_WIDTH:0] NB_LIMIT = (SELECT_WIDTH + 1)'(NB_WRAGENT);

  for (genvar i = 0; i < NB_RDAGENT; i++) begin : g_lane
    logic [RAM_LATENCY-1:0]  vld_q, vld_d;
    logic [SELECT_WIDTH-1:0] sel_aligned;
    logic [DATA_WIDTH-1:0]   mux_data;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   rddata_q, rddata_d;
    logic                    rdvalid_q, rderr_q, rderr_d;
    logic                    byp_hit_last;
    logic [DATA_WIDTH-1:0]   byp_data_last;

    // rdselect arrives one cycle after rden; bank data arrives RAM_LATENCY cycles after rden.
    if (RAM_LATENCY == 1) begin : g_sel_direct
      assign sel_aligned = rdselect[i*SELECT_WIDTH +: SELECT_WIDTH];
    end else begin : g_sel_pipe
      logic [SELECT_WIDTH-1:0] sel_q [RAM_LATENCY-1];
      always_ff @(posedge aclk) begin
        if (srst) begin
          for (int k = 0; k < RAM_LATENCY - 1; k++) sel_q[k] <= '0;
        end else begin
          sel_q[0] <= rdselect[i*SELECT_WIDTH +: SELECT_WIDTH];
          for (int k = 1; k < RAM_LATENCY - 1; k++) sel_q[k] <= sel_q[k-1];
        end
      end
      assign sel_aligned = sel_q[RAM_LATENCY-2];
    end

`ifdef WR_BYPASS_EN
    logic                   byp_hit_now;
    logic [DATA_WIDTH-1:0]  byp_data_now;
    logic [RAM_LATENCY-1:0] byp_hit_q;
    logic [DATA_WIDTH-1:0]  byp_data_q [RAM_LATENCY];

    // Ascending scan so the highest-numbered matching writer wins.
    always_comb begin
      byp_hit_now  = 1'b0;
      byp_data_now = '0;
      for (int j = 0; j < NB_WRAGENT; j++) begin
        if (wren[j] && (wraddr[j*ADDR_WIDTH +: ADDR_WIDTH] == rdaddr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
          byp_hit_now  = 1'b1;
          byp_data_now = wrdata[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    always_ff @(posedge aclk) begin
      if (srst) begin
        byp_hit_q <= '0;
        for (int k = 0; k < RAM_LATENCY; k++) byp_data_q[k] <= '0;
      end else begin
        byp_hit_q[0]  <= byp_hit_now;
        byp_data_q[0] <= byp_data_now;
        for (int k = 1; k < RAM_LATENCY; k++) begin
          byp_hit_q[k]  <= byp_hit_q[k-1];
          byp_data_q[k] <= byp_data_q[k-1];
        end
      end
    end

    assign byp_hit_last  = byp_hit_q[LAST];
    assign byp_data_last = byp_data_q[LAST];
`else
    logic unused_bypass_inputs;
    assign unused_bypass_inputs = ^{rdaddr[i*ADDR_WIDTH +: ADDR_WIDTH], wren, wraddr, wrdata};
    assign byp_hit_last  = 1'b0;
    assign byp_data_last = '0;
`endif

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
      vld_d    = vld_q << 1;
      vld_d[0] = rden[i];
      mux_data = '0;
      for (int j = 0; j < NB_WRAGENT; j++) begin
        if (sel_aligned == SELECT_WIDTH'(j))
          mux_data = bank_rddata[(i*NB_WRAGENT + j)*DATA_WIDTH +: DATA_WIDTH];
      end
      sel_err  = ({1'b0, sel_aligned} >= NB_LIMIT);
      rddata_d = mux_data;
      rderr_d  = sel_err;
      if (byp_hit_last) begin
        rddata_d = byp_data_last;
        rderr_d  = 1'b0;
      end
    end

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    // NOTE: the data register is reset too, since rddata must read zero out of reset.
    always_ff @(posedge aclk) begin
      if (srst) begin
        vld_q     <= '0;
        rdvalid_q <= 1'b0;
        rderr_q   <= 1'b0;
        rddata_q  <= '0;
      end else begin
        vld_q     <= vld_d;
        rdvalid_q <= vld_q[LAST];
        rderr_q   <= vld_q[LAST] & rderr_d;
        if (vld_q[LAST]) rddata_q <= rddata_d;
      end
    end

    assign rdvalid[i]                       = rdvalid_q;
    assign rderr[i]                         = rderr_q;
    assign rddata[i*DATA_WIDTH +: DATA_WIDTH] = rddata_q;
  end

endmodule

// File: tb/tb_read_path_aligner.sv
// Scoreboard bench for read_path_aligner: two configurations (latency 1 / 2 banks, latency 3 / 3 banks)
// driven from one directed stimulus table; expected responses are queued at issue and popped by monitors.
module tb_read_path_aligner;
  localparam int NCYC = 40;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int NR   = 2;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic clk;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done [2];

  bit            s_rst    [NCYC];
  bit            s_en     [NR][NCYC];
  logic [1:0]    s_sel    [NR][NCYC];
  logic [DW-1:0] s_word   [NR][NCYC];
  logic [AW-1:0] s_addr   [NR][NCYC];
  bit   [2:0]    s_wren   [NCYC];
  logic [AW-1:0] s_wraddr [NCYC][3];
  logic [DW-1:0] s_wrdata [NCYC][3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit en_at(input int i, input int c);
    return (c >= 0 && c < NCYC) ? s_en[i][c] : 1'b0;
  endfunction

  task automatic rd(input int i, input int c, input logic [AW-1:0] a, input logic [1:0] s,
                    input logic [DW-1:0] w);
    s_en[i][c]   = 1'b1;
    s_addr[i][c] = a;
    s_sel[i][c]  = s;
    s_word[i][c] = w;
  endtask

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int NW = (g == 0) ? 2 : 3;
    localparam int L  = (g == 0) ? 1 : 3;
    localparam int SW = (NW > 1) ? $clog2(NW) : 1;
    localparam int NSTEP = NCYC + L + 4;

    logic                srst;
    logic [NR-1:0]       rden, rdvalid, rderr;
    logic [NR*AW-1:0]    rdaddr;
    logic [NR*SW-1:0]    rdselect;
    logic [NR*NW*DW-1:0] bank_rddata;
    logic [NW-1:0]       wren;
    logic [NW*AW-1:0]    wraddr;
    logic [NW*DW-1:0]    wrdata;
    logic [NR*DW-1:0]    rddata;
    exp_t                exp_q [NR][$];

    read_path_aligner #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_WRAGENT(NW), .NB_RDAGENT(NR),
      .SELECT_WIDTH(SW), .RAM_LATENCY(L)
    ) dut (
      .aclk(clk), .srst(srst), .rden(rden), .rdaddr(rdaddr), .rdselect(rdselect),
      .bank_rddata(bank_rddata), .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
      .rdvalid(rdvalid), .rddata(rddata), .rderr(rderr)
    );

    // Driver: inputs for edge c are applied on the preceding falling edge.
    initial begin
      exp_t          e;
      logic [SW-1:0] sv;
      srst = 1'b1; rden = '0; rdaddr = '0; rdselect = '0; bank_rddata = '0;
      wren = '0; wraddr = '0; wrdata = '0;
      for (int c = 0; c < NSTEP; c++) begin
        @(negedge clk);
        srst = (c < NCYC) ? s_rst[c] : 1'b0;
        if (srst) for (int i = 0; i < NR; i++) exp_q[i].delete();
        for (int j = 0; j < NW; j++) begin
          wren[j]            = (c < NCYC) ? s_wren[c][j] : 1'b0;
          wraddr[j*AW +: AW] = (c < NCYC) ? s_wraddr[c][j] : '0;
          wrdata[j*DW +: DW] = (c < NCYC) ? s_wrdata[c][j] : '0;
        end
        for (int i = 0; i < NR; i++) begin
          rden[i]            = en_at(i, c);
          rdaddr[i*AW +: AW] = (c < NCYC) ? s_addr[i][c] : '0;
          rdselect[i*SW +: SW] = en_at(i, c - 1) ? s_sel[i][c-1][SW-1:0] : SW'($urandom);
          for (int j = 0; j < NW; j++) begin
            if (en_at(i, c - L))
              bank_rddata[(i*NW + j)*DW +: DW] = (SW'(j) == s_sel[i][c-L][SW-1:0]) ?
                s_word[i][c-L] : (s_word[i][c-L] ^ (DW'(j + 1) << 8));
            else
              bank_rddata[(i*NW + j)*DW +: DW] = $urandom;
          end
          if (rden[i] && !srst) begin
            sv     = s_sel[i][c][SW-1:0];
            e.due  = c + L + 1;
            e.data = s_word[i][c];
            e.err  = 1'b0;
            if (int'(sv) >= NW) begin
              e.data = '0;
              e.err  = 1'b1;
            end
`ifdef WR_BYPASS_EN
            for (int j = 0; j < NW; j++) begin
              if (s_wren[c][j] && s_wraddr[c][j] == s_addr[i][c]) begin
                e.data = s_wrdata[c][j];
                e.err  = 1'b0;
              end
            end
`endif
            exp_q[i].push_back(e);
          end
        end
      end
    end

    // Monitor: sampled 1 ns after edge e, i.e. the values presented during cycle e+1.
    initial begin
      exp_t x;
      bit   expv;
      for (int e = 0; e < NSTEP; e++) begin
        @(posedge clk);
        #1;
        if (e == 2) begin
          for (int i = 0; i < NR; i++)
            check($sformatf("cfg%0d lane%0d reset state", g, i),
                  {rdvalid[i], rderr[i], rddata[i*DW +: DW]}, '0);
        end
        for (int i = 0; i < NR; i++) begin
          expv = (exp_q[i].size() > 0) && (exp_q[i][0].due == e + 1);
          x.err = 1'b0;
          x.data = '0;
          if (expv) x = exp_q[i].pop_front();
          check($sformatf("cfg%0d lane%0d cycle%0d valid/err", g, i, e + 1),
                {rdvalid[i], rderr[i]}, {expv, expv & x.err});
          if (expv && rdvalid[i])
            check($sformatf("cfg%0d lane%0d cycle%0d rddata", g, i, e + 1),
                  rddata[i*DW +: DW], x.data);
        end
      end
      for (int i = 0; i < NR; i++)
        check($sformatf("cfg%0d lane%0d outstanding reads", g, i), exp_q[i].size(), 0);
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < NCYC; c++) begin
      s_rst[c]  = 1'b0;
      s_wren[c] = '0;
      for (int j = 0; j < 3; j++) begin
        s_wraddr[c][j] = '0;
        s_wrdata[c][j] = '0;
      end
      for (int i = 0; i < NR; i++) begin
        s_en[i][c] = 1'b0; s_sel[i][c] = '0; s_word[i][c] = '0; s_addr[i][c] = '0;
      end
    end
    for (int c = 0; c < 3; c++) s_rst[c] = 1'b1;
    // Single reads on both lanes in the same cycle with different selects.
    rd(0, 3, 8'h10, 2'd1, 32'hCAFE_0001);
    rd(1, 3, 8'h11, 2'd0, 32'h1111_0000);
    // Eight back-to-back reads, alternating select, plus concurrent lane-1 traffic.
    for (int k = 0; k < 8; k++) rd(0, 5 + k, AW'(8'h30 + k), 2'(k % 2), 32'hA000_0000 | DW'(k));
    rd(1, 8, 8'h40, 2'd2, 32'hB000_0002);
    rd(1, 9, 8'h41, 2'd1, 32'hB000_0003);
    // Select 3: out of range with three banks, truncates to bank 1 with two banks.
    rd(0, 15, 8'h50, 2'd3, 32'hDEAD_0003);
    rd(1, 16, 8'h51, 2'd3, 32'hDEAD_0013);
    rd(1, 17, 8'h52, 2'd2, 32'hBEEF_0002);
    // Reset pulse at 22 with reads in flight, a read during reset, and reads right after.
    rd(0, 19, 8'h58, 2'd0, 32'h5555_0019);
    rd(0, 21, 8'h59, 2'd1, 32'h5555_0021);
    rd(1, 21, 8'h5A, 2'd0, 32'h5555_1021);
    rd(1, 22, 8'h5B, 2'd1, 32'h5555_1022);
    s_rst[22] = 1'b1;
    rd(0, 23, 8'h60, 2'd1, 32'h600D_0001);
    rd(1, 23, 8'h61, 2'd0, 32'h600D_0010);
    // Same-cycle writes to the read address: 0x22 with bypass, bank data otherwise.
    rd(0, 28, 8'h20, 2'd0, 32'h0000_00FF);
    rd(1, 28, 8'h21, 2'd1, 32'h0000_0077);
    s_wren[28] = 3'b011;
    s_wraddr[28][0] = 8'h20; s_wrdata[28][0] = 32'h11;
    s_wraddr[28][1] = 8'h20; s_wrdata[28][1] = 32'h22;
    rd(0, 29, 8'h20, 2'd1, 32'h0000_00FF);
    s_wren[29] = 3'b001;
    s_wraddr[29][0] = 8'h20; s_wrdata[29][0] = 32'h33;

    for (int t = 0; t < 400 && !(done[0] && done[1]); t++) @(posedge clk);
    if (!(done[0] && done[1])) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: monitors done %0d%0d expected 11", done[0], done[1]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/read_path_aligner.md
# read_path_aligner

Downstream read stage of the multi-port RAM: consumes, per read agent, the last-writer select produced by the memory map accounter and the read data of every write-agent bank. It aligns the select with the bank read latency, muxes the correct bank, and registers the result with a valid strobe. It is the only block that drives read data back to the read agents.

## Interface
- ADDR_WIDTH, 8, read/write address width
- DATA_WIDTH, 32, data width of one bank word
- NB_WRAGENT, 2, number of write agents (= number of banks)
- NB_RDAGENT, 2, number of read agents
- SELECT_WIDTH, $clog2(NB_WRAGENT) (minimum 1), width of one bank select
- RAM_LATENCY, 1, bank read latency in cycles, legal 1..4
- aclk  in  1  clock; everything is on its rising edge
- srst  in  1  reset, synchronous, active-high
- rden  in  NB_RDAGENT  read request per read agent
- rdaddr  in  NB_RDAGENT*ADDR_WIDTH  read address per agent
- rdselect  in  NB_RDAGENT*SELECT_WIDTH  last-writer bank per agent, valid at T+1 for rden at T
- bank_rddata  in  NB_RDAGENT*NB_WRAGENT*DATA_WIDTH  bank outputs; slice [(i*NB_WRAGENT+j)*DATA_WIDTH +: DATA_WIDTH] is bank j for reader i
- wren  in  NB_WRAGENT  write strobes (bypass only)
- wraddr  in  NB_WRAGENT*ADDR_WIDTH  write addresses (bypass only)
- wrdata  in  NB_WRAGENT*DATA_WIDTH  write data (bypass only)
- rdvalid  out  NB_RDAGENT  one-cycle strobe, rddata valid
- rddata  out  NB_RDAGENT*DATA_WIDTH  read data per agent
- rderr  out  NB_RDAGENT  one-cycle strobe with rdvalid when select out of range

## Operation
- Per read agent, an independent identical lane; no interaction between lanes.
- Valid pipeline: rden shifted RAM_LATENCY+1 stages; last stage drives rdvalid.
- Select pipeline: rdselect captured at T+1, delayed so it meets bank data at T+RAM_LATENCY (RAM_LATENCY-1 extra stages; RAM_LATENCY=1 uses rdselect directly at T+1).
- Mux: rddata register loads bank_rddata slice indexed by aligned select when the aligned valid stage is set; otherwise holds its value.
- Select >= NB_WRAGENT (non power-of-2 NB_WRAGENT): rddata loads 0, rderr asserted with rdvalid.
- rdselect and bank_rddata are ignored in cycles without a matching in-flight request.
- Back-to-back reads on every cycle fully supported; one rdvalid per rden, in order.

## Timing
- rden at cycle T -> rdvalid and rddata at T+RAM_LATENCY+1 (registered output).
- Throughput 1 read/cycle/agent; no backpressure, no stall input.
- Reset: rdvalid=0, rderr=0, rddata=0, all pipeline stages cleared.
- srst high mid-operation: every in-flight request dropped; no rdvalid is produced for any rden sampled before or while srst is high. rden in the first cycle after srst deasserts is served normally.
- rden sampled while srst high is ignored.

## Configuration
- WR_BYPASS_EN defined: at cycle T, if any wren[j] with wraddr[j]==rdaddr[i], the lane captures wrdata[j] (highest j wins on multi-hit) and returns it at T+RAM_LATENCY+1 instead of the banked value; rderr forced 0 for that read. Covers RAMs without write-first behaviour.
- WR_BYPASS_EN undefined: wren/wraddr/wrdata unused; data comes from bank_rddata only; no bypass storage is instantiated.

## Test plan
- RAM_LATENCY=1, reader 0 rden at T addr 0x10, rdselect=1 at T+1, bank1=0xCAFE0001 at T+1 -> rdvalid[0] at T+2, rddata=0xCAFE0001, rderr=0.
- RAM_LATENCY=3, 8 back-to-back reads with alternating selects 0/1, distinct bank data -> 8 consecutive rdvalid cycles starting T+4, data in order matching select.
- NB_WRAGENT=3, rdselect=3 -> rdvalid with rddata=0, rderr=1 for exactly that cycle.
- Reads in flight, srst pulsed 1 cycle at T+1 -> no rdvalid for them; rden at first cycle after reset returns normally at +RAM_LATENCY+1.
- Both readers reading simultaneously with different selects -> independent correct rddata per lane same cycle.
- WR_BYPASS_EN: rden addr 0x20 with wren[0] and wren[1] to 0x20, wrdata 0x11/0x22, bank data 0xFF -> rddata=0x22; without macro -> 0xFF.
